// File: rtl/vector_control_unit_if.sv
// Decode/execute boundary bundle for vector_control_unit: decode-side request
// fields plus E-stage control word, with master (front end) and slave (unit) views.
interface vector_control_unit_if #(
  parameter int LANES = 4,
  parameter int VLEN  = 16
);
  localparam int NCH_MAX = VLEN / LANES;
  localparam int CW      = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;

  logic             InstrValidD;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic [CW+2:0]    VecLenD;
  logic             StallE;
  logic             FlushE;
  logic             BusyD;
  logic             PCSrcE;
  logic             RegWriteE;
  logic             MemToRegE;
  logic             MemWriteE;
  logic             BranchE;
  logic             ALUSrcE;
  logic             NoWriteE;
  logic [3:0]       ALUControlE;
  logic [1:0]       ImmSrcE;
  logic [1:0]       RegSrcE;
  logic             VecActiveE;
  logic             VecWriteE;
  logic [CW-1:0]    VecChunkE;
  logic             VecLastE;
  logic [LANES-1:0] VecMaskE;

  modport master (
    output InstrValidD, Op, Funct, Rd, VecLenD, StallE, FlushE,
    input  BusyD, PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE, ALUSrcE, NoWriteE,
    input  ALUControlE, ImmSrcE, RegSrcE, VecActiveE, VecWriteE, VecChunkE, VecLastE, VecMaskE
  );

  modport slave (
    input  InstrValidD, Op, Funct, Rd, VecLenD, StallE, FlushE,
    output BusyD, PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE, ALUSrcE, NoWriteE,
    output ALUControlE, ImmSrcE, RegSrcE, VecActiveE, VecWriteE, VecChunkE, VecLastE, VecMaskE
  );
endinterface

// File: rtl/vector_control_unit.sv
// Decode-stage control unit: scalar decode into a registered E word plus an IDLE/RUN
// sequencer that issues vector ops as LANES-wide chunks. Optional macro: VCU_TAIL_MASK_EN.
module vector_control_unit #(
  parameter int LANES = 4,
  parameter int VLEN  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  vector_control_unit_if.slave bus
);
  localparam int NCH_MAX = VLEN / LANES;
  localparam int CW      = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic             pcsrc;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             alu_src;
    logic             no_write;
    logic [3:0]       alu_control;
    logic [1:0]       imm_src;
    logic [1:0]       reg_src;
    logic             vec_active;
    logic             vec_write;
    logic [CW-1:0]    vec_chunk;
    logic             vec_last;
    logic [LANES-1:0] vec_mask;
  } eword_t;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [CW-1:0]    last_idx_q, last_idx_d;
  logic [LANES-1:0] tail_mask_q, tail_mask_d;
  eword_t           vword_q, vword_d;
  eword_t           e_q, e_d;

  eword_t           dec_s;
  logic             alu_op_s;
  logic             vec_ok_s;
  logic [CW-1:0]    last_idx_s;
  logic [LANES-1:0] tail_mask_s;
  logic [CW-1:0]    chunk_nx_s;

`ifdef VCU_TAIL_MASK_EN
  // Clamp the requested length to 1..VLEN and derive last chunk index and tail mask.
  always_comb begin : len_calc
    logic [31:0] len_v;
    logic [31:0] rem_v;
    len_v = 32'(bus.VecLenD);
    if (len_v == 32'd0) begin
      len_v = 32'd1;
    end else if (len_v > 32'(VLEN)) begin
      len_v = 32'(VLEN);
    end else begin
      len_v = len_v;
    end
    rem_v       = len_v % 32'(LANES);
    last_idx_s  = CW'((len_v - 32'd1) / 32'(LANES));
    tail_mask_s = (rem_v == 32'd0) ? {LANES{1'b1}} : LANES'((32'd1 << rem_v) - 32'd1);
  end
`else
  logic unused_len_s;
  assign unused_len_s = ^bus.VecLenD;
  assign last_idx_s   = CW'(NCH_MAX - 1);
  assign tail_mask_s  = {LANES{1'b1}};
`endif

  // Decode the D-stage instruction into the word E would receive on acceptance.
  always_comb begin
    dec_s    = '0;
    alu_op_s = 1'b0;
    vec_ok_s = 1'b0;
    if (!bus.InstrValidD) begin
      dec_s = '0;
    end else begin
      case (bus.Op)
        2'b00: begin
          dec_s.alu_src   = bus.Funct[5];
          dec_s.reg_write = 1'b1;
          alu_op_s        = 1'b1;
        end
        2'b01: begin
          dec_s.imm_src    = 2'b01;
          dec_s.alu_src    = 1'b1;
          dec_s.mem_to_reg = 1'b1;
          if (bus.Funct[0]) begin
            dec_s.reg_src   = 2'b01;
            dec_s.reg_write = 1'b1;
          end else begin
            dec_s.reg_src   = 2'b10;
            dec_s.mem_write = 1'b1;
          end
        end
        2'b10: begin
          dec_s.reg_src = 2'b01;
          dec_s.imm_src = 2'b10;
          dec_s.alu_src = 1'b1;
          dec_s.branch  = 1'b1;
        end
        2'b11: begin
          // Vector ALU chunks carry Funct[4:1] as the lane op; VLD/VST use add for addressing.
          if (!bus.Funct[4]) begin
            vec_ok_s          = 1'b1;
            dec_s.vec_write   = 1'b1;
            dec_s.alu_control = bus.Funct[4:1];
          end else if (bus.Funct[4:1] == 4'b1001) begin
            vec_ok_s         = 1'b1;
            dec_s.mem_to_reg = 1'b1;
            dec_s.vec_write  = 1'b1;
          end else if (bus.Funct[4:1] == 4'b1010) begin
            vec_ok_s        = 1'b1;
            dec_s.mem_write = 1'b1;
          end else begin
            vec_ok_s = 1'b0;
          end
          if (vec_ok_s) begin
            dec_s.alu_src    = bus.Funct[5];
            dec_s.vec_active = 1'b1;
            dec_s.vec_last   = (last_idx_s == '0);
            dec_s.vec_mask   = (last_idx_s == '0) ? tail_mask_s : {LANES{1'b1}};
          end else begin
            dec_s = '0;
          end
        end
        default: dec_s = '0;
      endcase
      if (bus.Op != 2'b11) begin
        if (alu_op_s) begin
          if (!bus.Funct[4]) begin
            dec_s.alu_control = bus.Funct[4:1];
          end else if (bus.Funct[4:1] == 4'b1000) begin
            dec_s.alu_control = 4'b0001;
            dec_s.no_write    = 1'b1;
          end else begin
            dec_s.alu_control = 4'b0000;
          end
        end else begin
          dec_s.alu_control = bus.Funct[5] ? 4'b0000 : 4'b0001;
        end
        dec_s.pcsrc = ((bus.Rd == 4'hF) & dec_s.reg_write & ~dec_s.no_write) | dec_s.branch;
      end else begin
        dec_s.pcsrc = 1'b0;
      end
    end
  end

  assign chunk_nx_s = chunk_q + CW'(1);

  // Sequencer next state: flush beats stall; a RUN sequence mid-flight re-issues the latched word.
  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    last_idx_d  = last_idx_q;
    tail_mask_d = tail_mask_q;
    vword_d     = vword_q;
    e_d         = e_q;
    if (bus.FlushE) begin
      e_d     = '0;
      state_d = S_IDLE;
      chunk_d = '0;
    end else if (bus.StallE) begin
      e_d = e_q;
    end else if ((state_q == S_RUN) && (chunk_q != last_idx_q)) begin
      chunk_d      = chunk_nx_s;
      e_d          = vword_q;
      e_d.vec_chunk = chunk_nx_s;
      e_d.vec_last  = (chunk_nx_s == last_idx_q);
      e_d.vec_mask  = (chunk_nx_s == last_idx_q) ? tail_mask_q : {LANES{1'b1}};
    end else begin
      e_d     = dec_s;
      state_d = S_IDLE;
      chunk_d = '0;
      if (vec_ok_s && (last_idx_s != '0)) begin
        state_d     = S_RUN;
        vword_d     = dec_s;
        last_idx_d  = last_idx_s;
        tail_mask_d = tail_mask_s;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State, sequencer latches and the registered E word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      chunk_q     <= '0;
      last_idx_q  <= '0;
      tail_mask_q <= '0;
      vword_q     <= '0;
      e_q         <= '0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      last_idx_q  <= last_idx_d;
      tail_mask_q <= tail_mask_d;
      vword_q     <= vword_d;
      e_q         <= e_d;
    end
  end

  assign bus.BusyD = bus.StallE ? ((state_q == S_RUN) | vec_ok_s)
                                : ((state_q == S_RUN) & (chunk_q != last_idx_q));

  assign bus.PCSrcE      = e_q.pcsrc;
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemToRegE   = e_q.mem_to_reg;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.NoWriteE    = e_q.no_write;
  assign bus.ALUControlE = e_q.alu_control;
  assign bus.ImmSrcE     = e_q.imm_src;
  assign bus.RegSrcE     = e_q.reg_src;
  assign bus.VecActiveE  = e_q.vec_active;
  assign bus.VecWriteE   = e_q.vec_write;
  assign bus.VecChunkE   = e_q.vec_chunk;
  assign bus.VecLastE    = e_q.vec_last;
  assign bus.VecMaskE    = e_q.vec_mask;
endmodule

// File: tb/tb_vector_control_unit.sv
// Scoreboard bench for vector_control_unit: a chunk-list reference model predicts each
// E word and BusyD; monitors pop and compare. Honours VCU_TAIL_MASK_EN like the design.
module tb_vector_control_unit;
  localparam int LANES   = 4;
  localparam int VLEN    = 16;
  localparam int NCH_MAX = VLEN / LANES;
  localparam int CW      = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;

  typedef struct packed {
    logic             pcsrc;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             alu_src;
    logic             no_write;
    logic [3:0]       alu_control;
    logic [1:0]       imm_src;
    logic [1:0]       reg_src;
    logic             vec_active;
    logic             vec_write;
    logic [CW-1:0]    vec_chunk;
    logic             vec_last;
    logic [LANES-1:0] vec_mask;
  } ew_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vector_control_unit_if #(.LANES(LANES), .VLEN(VLEN)) bus ();

  vector_control_unit #(.LANES(LANES), .VLEN(VLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  ew_t cur_m;
  ew_t fut_m[$];
  bit  multi_m;
  ew_t exp_e_q[$];
  bit  exp_b_q[$];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ew_t actual_word();
    ew_t w;
    w.pcsrc       = bus.PCSrcE;
    w.reg_write   = bus.RegWriteE;
    w.mem_to_reg  = bus.MemToRegE;
    w.mem_write   = bus.MemWriteE;
    w.branch      = bus.BranchE;
    w.alu_src     = bus.ALUSrcE;
    w.no_write    = bus.NoWriteE;
    w.alu_control = bus.ALUControlE;
    w.imm_src     = bus.ImmSrcE;
    w.reg_src     = bus.RegSrcE;
    w.vec_active  = bus.VecActiveE;
    w.vec_write   = bus.VecWriteE;
    w.vec_chunk   = bus.VecChunkE;
    w.vec_last    = bus.VecLastE;
    w.vec_mask    = bus.VecMaskE;
    return w;
  endfunction

  function automatic bit vec_valid(input bit v, input logic [1:0] op, input logic [5:0] f);
    return v && (op == 2'd3) && (f[4:1] < 4'd8 || f[4:1] == 4'd9 || f[4:1] == 4'd10);
  endfunction

  // Reference decode straight from the control table: {RegSrc,ImmSrc,ALUSrc,MemToReg,RegWrite,MemWrite,Branch,ALUOp}
  function automatic ew_t decode_m(input bit v, input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    ew_t w;
    logic [9:0] t;
    w = '0;
    if (!v) return w;
    if (op == 2'd3) begin
      if (!vec_valid(v, op, f)) return w;
      w.vec_active = 1'b1;
      w.alu_src    = f[5];
      if (f[4:1] < 4'd8) begin
        w.vec_write = 1'b1; w.alu_control = f[4:1];
      end else if (f[4:1] == 4'd9) begin
        w.mem_to_reg = 1'b1; w.vec_write = 1'b1;
      end else begin
        w.mem_write = 1'b1;
      end
      return w;
    end
    if (op == 2'd0)      t = f[5] ? 10'b00_00_1_0_1_0_0_1 : 10'b00_00_0_0_1_0_0_1;
    else if (op == 2'd1) t = f[0] ? 10'b01_01_1_1_1_0_0_0 : 10'b10_01_1_1_0_1_0_0;
    else                 t = 10'b01_10_1_0_0_0_1_0;
    w.reg_src = t[9:8]; w.imm_src = t[7:6]; w.alu_src = t[5]; w.mem_to_reg = t[4];
    w.reg_write = t[3]; w.mem_write = t[2]; w.branch = t[1];
    if (t[0]) begin
      if (f[4:1] < 4'd8)       w.alu_control = f[4:1];
      else if (f[4:1] == 4'd8) begin w.alu_control = 4'd1; w.no_write = 1'b1; end
      else                     w.alu_control = 4'd0;
    end else begin
      w.alu_control = f[5] ? 4'd0 : 4'd1;
    end
    w.pcsrc = ((rd == 4'hF) && w.reg_write && !w.no_write) || w.branch;
    return w;
  endfunction

  task automatic chunk_plan(input int len_in, output int n, output logic [LANES-1:0] tm);
    int l;
`ifdef VCU_TAIL_MASK_EN
    l  = (len_in == 0) ? 1 : ((len_in > VLEN) ? VLEN : len_in);
    n  = (l + LANES - 1) / LANES;
    tm = ((l % LANES) == 0) ? {LANES{1'b1}} : LANES'((1 << (l % LANES)) - 1);
`else
    l  = len_in;
    n  = VLEN / LANES;
    tm = {LANES{1'b1}};
`endif
  endtask

  task automatic drive_cycle(input bit r, input bit v, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [CW+2:0] len, input bit st, input bit fl);
    ew_t base;
    ew_t w;
    int n;
    logic [LANES-1:0] tm;
    @(posedge clk);
    #2;
    reset           = r ? 1'b0 : 1'b1;
    bus.InstrValidD = v;
    bus.Op          = op;
    bus.Funct       = f;
    bus.Rd          = rd;
    bus.VecLenD     = len;
    bus.StallE      = st;
    bus.FlushE      = fl;
    #1;
    if (r) begin
      cur_m = '0; fut_m.delete(); multi_m = 1'b0;
      check_val("reset_zero", 32'({bus.BusyD, actual_word()}), 32'd0);
    end
    exp_b_q.push_back(st ? (multi_m || vec_valid(v, op, f)) : (fut_m.size() > 0));
    if (r || fl) begin
      cur_m = '0; fut_m.delete(); multi_m = 1'b0;
    end else if (st) begin
      cur_m = cur_m;
    end else if (fut_m.size() > 0) begin
      cur_m = fut_m.pop_front();
    end else begin
      base    = decode_m(v, op, f, rd);
      multi_m = 1'b0;
      if (base.vec_active) begin
        chunk_plan(int'(len), n, tm);
        for (int i = 0; i < n; i++) begin
          w           = base;
          w.vec_chunk = CW'(i);
          w.vec_last  = (i == n - 1);
          w.vec_mask  = (i == n - 1) ? tm : {LANES{1'b1}};
          if (i == 0) cur_m = w;
          else        fut_m.push_back(w);
        end
        multi_m = (n > 1);
      end else begin
        cur_m = base;
      end
    end
    exp_e_q.push_back(cur_m);
  endtask

  // E-word monitor: one expectation per edge.
  initial begin
    ew_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_e_q.size() > 0) begin
        e = exp_e_q.pop_front();
        check_val("e_word", 32'(actual_word()), 32'(e));
      end
    end
  end

  // BusyD monitor: sampled mid-cycle once inputs have settled.
  initial begin
    bit b;
    forever begin
      @(negedge clk);
      if (exp_b_q.size() > 0) begin
        b = exp_b_q.pop_front();
        check_val("busy_d", 32'(bus.BusyD), 32'(b));
      end
    end
  end

  initial begin
    bit r, v, st, fl;
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    logic [CW+2:0] len;
    bus.InstrValidD = 1'b0; bus.Op = 2'b00; bus.Funct = 6'b000000; bus.Rd = 4'h0;
    bus.VecLenD = '0; bus.StallE = 1'b0; bus.FlushE = 1'b0;
    multi_m = 1'b0; cur_m = '0;
    repeat (2) @(posedge clk);
    drive_cycle(1'b1, 1'b0, 2'd0, 6'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 2'd0, 6'b100100, 4'hF, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 2'd0, 6'b010000, 4'hF, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 2'd1, 6'b000001, 4'hF, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 2'd2, 6'b000000, 4'h3, 5'd0, 1'b0, 1'b0);
    repeat (5) drive_cycle(1'b0, 1'b1, 2'd3, 6'b000000, 4'h1, 5'd16, 1'b0, 1'b0);
    repeat (4) drive_cycle(1'b0, 1'b1, 2'd3, 6'b100010, 4'h2, 5'd10, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b1, 2'd3, 6'b010010, 4'h2, 5'd0, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b0, 2'd0, 6'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b1, 2'd3, 6'b000010, 4'h1, 5'd16, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b1, 2'd3, 6'b000010, 4'h1, 5'd16, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 2'd3, 6'b000010, 4'h1, 5'd16, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 2'd0, 6'b100100, 4'hF, 5'd0, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b1, 2'd3, 6'b000100, 4'h1, 5'd16, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'd0, 6'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 2'd0, 6'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 9) < 8);
      op  = ($urandom_range(0, 9) < 4) ? 2'd3 : 2'($urandom_range(0, 2));
      f   = 6'($urandom_range(0, 63));
      rd  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      len = (CW+3)'($urandom_range(0, 31));
      st  = ($urandom_range(0, 99) < 15);
      fl  = ($urandom_range(0, 99) < 4);
      if (r) drive_cycle(1'b1, 1'b0, 2'd0, 6'd0, 4'h0, '0, 1'b0, 1'b0);
      else   drive_cycle(1'b0, v, op, f, rd, len, st, fl);
    end
    repeat (3) @(posedge clk);
    #4;
    if (exp_e_q.size() != 0 || exp_b_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp_e_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
